// File: rtl/eth_pkg.sv
// Shared Ethernet block definitions: TX arbiter FSM states and width helpers.
// Also used by the RX-side distributor so both ends size their buses the same way.
package eth_pkg;

    // TX buffer arbiter states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEND  = 2'd2,
        ST_COOL  = 2'd3
    } eth_tx_arb_state_e;

    localparam int unsigned ETH_MTU_DEFAULT        = 2048;
    localparam int unsigned ETH_DATA_WIDTH_DEFAULT = 32;

    // clog2 that never returns 0, so a 1-entry index still gets one bit
    function automatic int unsigned safe_clog2(input int unsigned x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // Bits needed to hold the value x itself (0..x inclusive)
    function automatic int unsigned width_for(input int unsigned x);
        return $clog2(x + 1);
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// MAC transmit-buffer write-side bus.
// master: the arbiter (drives send strobe and buffer writes, sees packet_req_i).
// slave : the MAC (receives the writes, reports buffer-free on packet_req_i).
interface eth_tx_arbiter_if
    import eth_pkg::*;
#(
    parameter int unsigned eth_mtu_p    = ETH_MTU_DEFAULT,
    parameter int unsigned data_width_p = ETH_DATA_WIDTH_DEFAULT,
    localparam int unsigned addr_width_lp        = $clog2(eth_mtu_p),
    localparam int unsigned packet_size_width_lp = width_for(eth_mtu_p),
    localparam int unsigned size_width_lp        = width_for(safe_clog2(data_width_p / 8))
);

    logic                            packet_send_o;
    logic                            packet_req_i;
    logic                            packet_wsize_valid_o;
    logic [packet_size_width_lp-1:0] packet_wsize_o;
    logic                            packet_wvalid_o;
    logic [addr_width_lp-1:0]        packet_waddr_o;
    logic [data_width_p-1:0]         packet_wdata_o;
    logic [size_width_lp-1:0]        packet_wdata_size_o;

    modport master (
        output packet_send_o,
        input  packet_req_i,
        output packet_wsize_valid_o,
        output packet_wsize_o,
        output packet_wvalid_o,
        output packet_waddr_o,
        output packet_wdata_o,
        output packet_wdata_size_o
    );

    modport slave (
        input  packet_send_o,
        output packet_req_i,
        input  packet_wsize_valid_o,
        input  packet_wsize_o,
        input  packet_wvalid_o,
        input  packet_waddr_o,
        input  packet_wdata_o,
        input  packet_wdata_size_o
    );

endinterface

// File: rtl/eth_rr_arbiter.sv
// Combinational N-way round-robin picker.
// Ports: req_i (request levels), last_i (index granted last time),
//        grant_o (one-hot winner), id_o (winner index), valid_o (any winner).
// Search starts at last_i+1 and wraps modulo num_clients_p.
module eth_rr_arbiter
    import eth_pkg::*;
#(
    parameter int unsigned num_clients_p = 2,
    localparam int unsigned id_width_lp  = safe_clog2(num_clients_p)
) (
    input  logic [num_clients_p-1:0] req_i,
    input  logic [id_width_lp-1:0]   last_i,
    output logic [num_clients_p-1:0] grant_o,
    output logic [id_width_lp-1:0]   id_o,
    output logic                     valid_o
);

    // First requester found walking forward from last_i+1
    always_comb begin
        int unsigned idx;
        logic        found;
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 1; i <= num_clients_p; i++) begin
            idx = (32'(last_i) + i) % num_clients_p;
            if (!found && req_i[id_width_lp'(idx)]) begin
                found                         = 1'b1;
                grant_o[id_width_lp'(idx)]    = 1'b1;
                id_o                          = id_width_lp'(idx);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin owner of the MAC single-packet transmit buffer.
// Ports:
//   clk_i, reset_n_i         : clock, async active-low reset
//   client_req_i             : per-client request level
//   client_grant_o           : one-hot buffer ownership (registered)
//   client_send_i            : per-client send strobe (owner's only is honoured)
//   client_w*_i              : per-client buffer write signals
//   mac                      : MAC write-side bus (send strobe, packet_req_i, muxed writes)
//   owner_o                  : current or last owner index
//   busy_o                   : arbiter not idle
//   timeout_o                : one-cycle pulse when the watchdog revokes a grant
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int unsigned num_clients_p = 2,
    parameter int unsigned eth_mtu_p     = ETH_MTU_DEFAULT,
    parameter int unsigned data_width_p  = ETH_DATA_WIDTH_DEFAULT,
    parameter int unsigned timeout_p     = 4096,
    localparam int unsigned addr_width_lp        = $clog2(eth_mtu_p),
    localparam int unsigned packet_size_width_lp = width_for(eth_mtu_p),
    localparam int unsigned size_width_lp        = width_for(safe_clog2(data_width_p / 8)),
    localparam int unsigned id_width_lp          = safe_clog2(num_clients_p)
) (
    input  logic                                               clk_i,
    input  logic                                               reset_n_i,
    input  logic [num_clients_p-1:0]                           client_req_i,
    output logic [num_clients_p-1:0]                           client_grant_o,
    input  logic [num_clients_p-1:0]                           client_send_i,
    input  logic [num_clients_p-1:0]                           client_wsize_valid_i,
    input  logic [num_clients_p-1:0][packet_size_width_lp-1:0] client_wsize_i,
    input  logic [num_clients_p-1:0]                           client_wvalid_i,
    input  logic [num_clients_p-1:0][addr_width_lp-1:0]        client_waddr_i,
    input  logic [num_clients_p-1:0][data_width_p-1:0]         client_wdata_i,
    input  logic [num_clients_p-1:0][size_width_lp-1:0]        client_wdata_size_i,
    eth_tx_arbiter_if.master                                   mac,
    output logic [id_width_lp-1:0]                             owner_o,
    output logic                                               busy_o,
    output logic                                               timeout_o
);

    // Watchdog sizing; a zero timeout disables it but keeps a 1-bit counter
    localparam bit          wd_en_lp   = (timeout_p != 0);
    localparam int unsigned cnt_w_lp   = wd_en_lp ? width_for(timeout_p) : 1;
    localparam int unsigned to_last_lp = wd_en_lp ? timeout_p - 1 : 0;

    eth_tx_arb_state_e              state_q, state_d;
    logic [num_clients_p-1:0]       grant_q, grant_d;
    logic [id_width_lp-1:0]         owner_q, owner_d;
    logic [id_width_lp-1:0]         last_q, last_d;
    logic [cnt_w_lp-1:0]            cnt_q, cnt_d;
    logic                           send_q, send_d;
    logic                           timeout_q, timeout_d;
    logic                           busy_q, busy_d;

    logic [num_clients_p-1:0]       rr_grant;
    logic [id_width_lp-1:0]         rr_id;
    logic                           rr_valid;
    logic                           in_grant;

    eth_rr_arbiter #(
        .num_clients_p (num_clients_p)
    ) u_rr (
        .req_i   (client_req_i),
        .last_i  (last_q),
        .grant_o (rr_grant),
        .id_o    (rr_id),
        .valid_o (rr_valid)
    );

    // State and registered outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= id_width_lp'(num_clients_p - 1);
            cnt_q     <= '0;
            send_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            send_q    <= send_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        send_d    = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rr_valid && mac.packet_req_i) begin
                    grant_d = rr_grant;
                    owner_d = rr_id;
                    last_d  = rr_id;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Send is checked first so it beats a same-cycle watchdog expiry
                if (client_send_i[owner_q]) begin
                    grant_d = '0;
                    send_d  = 1'b1;
                    state_d = ST_SEND;
                end else if (wd_en_lp && (cnt_q == cnt_w_lp'(to_last_lp))) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_COOL;
                end else if (cnt_q != {cnt_w_lp{1'b1}}) begin
                    cnt_d = cnt_q + cnt_w_lp'(1);
                end
            end
            ST_SEND: begin
                state_d = ST_COOL;
            end
            ST_COOL: begin
                // Gives the MAC a cycle to drop packet_req_i before re-arbitrating
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Owner's write side goes straight through while it holds the buffer
    assign in_grant = (state_q == ST_GRANT);

    assign mac.packet_wsize_valid_o = in_grant & client_wsize_valid_i[owner_q];
    assign mac.packet_wsize_o       = in_grant ? client_wsize_i[owner_q]      : '0;
    assign mac.packet_wvalid_o      = in_grant & client_wvalid_i[owner_q];
    assign mac.packet_waddr_o       = in_grant ? client_waddr_i[owner_q]      : '0;
    assign mac.packet_wdata_o       = in_grant ? client_wdata_i[owner_q]      : '0;
    assign mac.packet_wdata_size_o  = in_grant ? client_wdata_size_i[owner_q] : '0;
    assign mac.packet_send_o        = send_q;

    assign client_grant_o = grant_q;
    assign owner_o        = owner_q;
    assign busy_o         = busy_q;
    assign timeout_o      = timeout_q;

endmodule
